// File: rtl/speed_test_pkg.sv
// Shared definitions for the speed test frame checker.
//   - port_config field offsets and widths
//   - check_results field offsets and widths
//   - checker state enum
//   - ETHERTYPE_IPV4 and a MAC byte extraction helper
package speed_test_pkg;

   localparam int CFG_W              = 174;
   localparam int CFG_MAC_W          = 48;
   localparam int CFG_IP_W           = 32;
   localparam int CFG_LOCAL_MAC_LSB  = 0;
   localparam int CFG_REMOTE_MAC_LSB = 48;
   localparam int CFG_SRC_IP_LSB     = 96;
   localparam int CFG_DST_IP_LSB     = 128;
   localparam int CFG_LEN_LSB        = 160;
   localparam int CFG_LEN_W          = 11;
   localparam int CFG_RATE_LSB       = 171;
   localparam int CFG_RATE_W         = 3;

   localparam int RES_W          = 128;
   localparam int RES_BYTES_LSB  = 0;
   localparam int RES_BYTES_W    = 64;
   localparam int RES_GOOD_LSB   = 64;
   localparam int RES_GOOD_W     = 32;
   localparam int RES_ERR_LSB    = 96;
   localparam int RES_ERR_W      = 32;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } checker_state_e;

   // Byte k of a MAC address in wire order (byte 0 = bits [47:40]).
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
      logic [7:0] b;
      case (k)
         3'd0:    b = mac[47:40];
         3'd1:    b = mac[39:32];
         3'd2:    b = mac[31:24];
         3'd3:    b = mac[23:16];
         3'd4:    b = mac[15:8];
         default: b = mac[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/speed_test_frame_checker_if.sv
// RX byte stream from the MAC into the frame checker.
//   tdata  : received byte
//   tvalid : byte valid
//   tlast  : last byte of the frame
//   tuser  : MAC error flag, meaningful only on the tlast beat
// Handshake: there is no ready. Every cycle with tvalid=1 is one consumed
// beat; the sink can never stall the source.
interface speed_test_frame_checker_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, tvalid, tlast, tuser);
   modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/speed_test_frame_parser.sv
// Per-frame parser: tracks the byte index, the header match (destination MAC
// and EtherType) and, with SPEED_TEST_CHECKER_SEQ_EN, the sequence number.
// Emits a one-cycle verdict the cycle after each tlast beat.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   tdata..tuser      RX stream beat
//   start             test start pulse; marks any in-flight frame as ignored
//   local_mac,exp_len latched test config
//   busy              a counted frame has started and not yet ended
//   verdict_*         valid pulse, header match, good frame, frame length
module speed_test_frame_parser
   import speed_test_pkg::*;
#(
   parameter logic [15:0] ETHERTYPE   = ETHERTYPE_IPV4,
   parameter int          MIN_HDR_LEN = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  tdata,
   input  logic        tvalid,
   input  logic        tlast,
   input  logic        tuser,
   input  logic        start,
   input  logic [47:0] local_mac,
   input  logic [10:0] exp_len,
   output logic        busy,
   output logic        verdict_valid,
   output logic        verdict_match,
   output logic        verdict_good,
   output logic [11:0] verdict_len
);

   logic [10:0] byte_idx;
   logic        in_frame;   // beats seen since the last tlast
   logic        skip;       // current frame began before the latest start
   logic        hdr_ok;     // header bytes matched so far
   logic        byte_ok;
   logic        hdr_now;
   logic        match_now;
   logic        good_now;
   logic        seq_ok;
   logic [11:0] frame_len;

   always_comb begin
      byte_ok = 1'b1;
      if (byte_idx < 11'd6)
         byte_ok = (tdata == mac_byte(local_mac, byte_idx[2:0]));
      else if (byte_idx == 11'd12)
         byte_ok = (tdata == ETHERTYPE[15:8]);
      else if (byte_idx == 11'd13)
         byte_ok = (tdata == ETHERTYPE[7:0]);
      hdr_now   = ((byte_idx == 11'd0) || hdr_ok) && byte_ok;
      frame_len = {1'b0, byte_idx} + 12'd1;
      match_now = hdr_now && (frame_len >= 12'(MIN_HDR_LEN));
      good_now  = match_now && !tuser && (frame_len == {1'b0, exp_len}) && seq_ok;
   end

   assign busy = !skip && (in_frame || tvalid);

`ifdef SPEED_TEST_CHECKER_SEQ_EN
   logic [31:0] seq_sr;
   logic [31:0] seq_exp;
   logic [31:0] seq_now;
   logic        seq_seen;
   logic        seq_long;

   always_comb begin
      // When tlast lands on byte 45 the last sequence byte is still on tdata.
      seq_now  = (byte_idx == 11'd45) ? {seq_sr[23:0], tdata} : seq_sr;
      seq_long = (frame_len >= 12'd46);
      seq_ok   = seq_long && (!seq_seen || (seq_now == seq_exp));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seq_sr   <= '0;
         seq_exp  <= '0;
         seq_seen <= 1'b0;
      end else begin
         if (tvalid && (byte_idx >= 11'd42) && (byte_idx <= 11'd45))
            seq_sr <= {seq_sr[23:0], tdata};
         if (start)
            seq_seen <= 1'b0;
         else if (tvalid && tlast && !skip && match_now && seq_long) begin
            seq_exp  <= seq_now + 32'd1;
            seq_seen <= 1'b1;
         end
      end
   end
`else
   assign seq_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_idx      <= '0;
         in_frame      <= 1'b0;
         skip          <= 1'b0;
         hdr_ok        <= 1'b0;
         verdict_valid <= 1'b0;
         verdict_match <= 1'b0;
         verdict_good  <= 1'b0;
         verdict_len   <= '0;
      end else begin
         verdict_valid <= 1'b0;
         if (tvalid) begin
            if (tlast) begin
               byte_idx      <= '0;
               in_frame      <= 1'b0;
               // A frame ending on the start cycle belongs to the old window.
               verdict_valid <= !skip && !start;
               verdict_match <= match_now;
               verdict_good  <= good_now;
               verdict_len   <= frame_len;
            end else begin
               if (byte_idx != 11'h7FF)
                  byte_idx <= byte_idx + 11'd1;
               in_frame <= 1'b1;
               hdr_ok   <= hdr_now;
            end
         end
         if (start)
            skip <= tvalid ? !tlast : in_frame;
         else if (tvalid && tlast)
            skip <= 1'b0;
      end
   end

endmodule

// File: rtl/speed_test_frame_checker.sv
// Receive-side speed test checker for one port. Counts good frames, good
// bytes and errored frames addressed to the latched local MAC while a test
// runs; results are frozen once the test ends.
// Optional feature macro: SPEED_TEST_CHECKER_SEQ_EN (sequence number check
// on bytes 42-45, handled inside speed_test_frame_parser).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   s_axis         RX byte stream (slave modport, no ready)
//   start, stop    one-cycle control pulses; start wins when both are high
//   port_config    test config (local MAC and frame length are used here)
//   check_ready    high in IDLE or DONE; results are valid
//   check_results  {error frames, good frames, good bytes}
//   dbg_state      current FSM state
module speed_test_frame_checker
   import speed_test_pkg::*;
#(
   parameter logic [15:0] ETHERTYPE   = ETHERTYPE_IPV4,
   parameter int          MIN_HDR_LEN = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   speed_test_frame_checker_if.slave s_axis,
   input  logic                 start,
   input  logic                 stop,
   input  logic [CFG_W-1:0]     port_config,
   output logic                 check_ready,
   output logic [RES_W-1:0]     check_results,
   output checker_state_e       dbg_state
);

   checker_state_e state_q, state_d;
   logic [CFG_MAC_W-1:0]   cfg_mac_q;
   logic [CFG_LEN_W-1:0]   cfg_len_q;
   logic [RES_BYTES_W-1:0] good_bytes_q;
   logic [RES_GOOD_W-1:0]  good_frames_q;
   logic [RES_ERR_W-1:0]   err_frames_q;
   logic                   busy;
   logic                   verdict_valid;
   logic                   verdict_match;
   logic                   verdict_good;
   logic [11:0]            verdict_len;
   logic                   counting;
   logic                   unused_cfg;

   // Remote MAC, IPs and rate select only concern the generator.
   assign unused_cfg = ^port_config[CFG_REMOTE_MAC_LSB +: CFG_MAC_W]
                     ^ ^port_config[CFG_SRC_IP_LSB +: CFG_IP_W]
                     ^ ^port_config[CFG_DST_IP_LSB +: CFG_IP_W]
                     ^ ^port_config[CFG_RATE_LSB +: CFG_RATE_W];

   speed_test_frame_parser #(
      .ETHERTYPE   (ETHERTYPE),
      .MIN_HDR_LEN (MIN_HDR_LEN)
   ) u_parser (
      .clk           (clk),
      .rst_n         (rst_n),
      .tdata         (s_axis.tdata),
      .tvalid        (s_axis.tvalid),
      .tlast         (s_axis.tlast),
      .tuser         (s_axis.tuser),
      .start         (start),
      .local_mac     (cfg_mac_q),
      .exp_len       (cfg_len_q),
      .busy          (busy),
      .verdict_valid (verdict_valid),
      .verdict_match (verdict_match),
      .verdict_good  (verdict_good),
      .verdict_len   (verdict_len)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (start)     state_d = ST_RUNNING;
            else if (stop) state_d = busy ? ST_DRAIN : ST_DONE;
         end
         ST_DRAIN: begin
            // Leave on the same edge that books the last frame, so ready
            // rises together with the final counts.
            if (start)              state_d = ST_RUNNING;
            else if (verdict_valid) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   assign counting = (state_q == ST_RUNNING) || (state_q == ST_DRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_mac_q     <= '0;
         cfg_len_q     <= '0;
         good_bytes_q  <= '0;
         good_frames_q <= '0;
         err_frames_q  <= '0;
      end else if (start) begin
         cfg_mac_q     <= port_config[CFG_LOCAL_MAC_LSB +: CFG_MAC_W];
         cfg_len_q     <= port_config[CFG_LEN_LSB +: CFG_LEN_W];
         good_bytes_q  <= '0;
         good_frames_q <= '0;
         err_frames_q  <= '0;
      end else if (counting && verdict_valid && verdict_match) begin
         if (verdict_good) begin
            if (good_frames_q != '1) good_frames_q <= good_frames_q + 32'd1;
            good_bytes_q <= good_bytes_q + 64'(verdict_len);
         end else if (err_frames_q != '1) begin
            err_frames_q <= err_frames_q + 32'd1;
         end
      end
   end

   assign check_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign dbg_state   = state_q;

   always_comb begin
      check_results = '0;
      check_results[RES_BYTES_LSB +: RES_BYTES_W] = good_bytes_q;
      check_results[RES_GOOD_LSB  +: RES_GOOD_W]  = good_frames_q;
      check_results[RES_ERR_LSB   +: RES_ERR_W]   = err_frames_q;
   end

endmodule

// File: tb/tb_speed_test_frame_checker.sv
// Bench for speed_test_frame_checker: directed scenarios plus randomized
// frame mixes, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_speed_test_frame_checker;
   import speed_test_pkg::*;

   // ---------------- clock / reset ----------------
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           stop = 1'b0;
   logic [173:0]   port_config = '0;
   logic           check_ready;
   logic [127:0]   check_results;
   checker_state_e dbg_state;

   speed_test_frame_checker_if axis ();

   speed_test_frame_checker dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis        (axis.slave),
      .start         (start),
      .stop          (stop),
      .port_config   (port_config),
      .check_ready   (check_ready),
      .check_results (check_results),
      .dbg_state     (dbg_state)
   );

   always #4 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // ---------------- scoreboard / model state ----------------
   int           checks = 0;
   int           failures = 0;
   logic [7:0]   frm [0:2047];
   int           frm_len;
   logic         frm_tuser;
   logic [47:0]  m_mac;
   int           m_len;
   logic [63:0]  exp_bytes;
   logic [31:0]  exp_good;
   logic [31:0]  exp_err;
   logic [31:0]  m_seq_exp;
   bit           m_seq_valid;
   logic [31:0]  tx_seq = 32'd100;
   logic [127:0] exp_q [$];

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: classifies a whole frame from its bytes.
   task automatic model_reset(input logic [47:0] mac, input int len);
      m_mac = mac; m_len = len;
      exp_bytes = '0; exp_good = '0; exp_err = '0;
      m_seq_valid = 1'b0; m_seq_exp = '0;
   endtask

   task automatic model_frame();
      logic [47:0] d;
      logic [15:0] e;
      logic [31:0] s;
      bit          ok;
      if (frm_len < 14) return;
      d = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
      e = {frm[12], frm[13]};
      if (d != m_mac || e != 16'h0800) return;
      ok = !frm_tuser && (frm_len == m_len);
`ifdef SPEED_TEST_CHECKER_SEQ_EN
      if (frm_len < 46) ok = 1'b0;
      else begin
         s = {frm[42], frm[43], frm[44], frm[45]};
         if (m_seq_valid && s != m_seq_exp) ok = 1'b0;
         m_seq_exp = s + 32'd1;
         m_seq_valid = 1'b1;
      end
`else
      s = '0;
`endif
      if (ok) begin
         if (exp_good != '1) exp_good++;
         exp_bytes += 64'(frm_len);
      end else if (exp_err != '1) exp_err++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                              input logic [31:0] seq, input logic tu);
      for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) if (i < len) frm[i] = dst[47-8*i -: 8];
      if (len > 12) frm[12] = et[15:8];
      if (len > 13) frm[13] = et[7:0];
      for (int k = 0; k < 4; k++) if (42 + k < len) frm[42+k] = seq[31-8*k -: 8];
      frm_len = len;
      frm_tuser = tu;
   endtask

   task automatic drive_beat(input int i, input bit st, input bit sp);
      axis.tdata  = frm[i];
      axis.tvalid = 1'b1;
      axis.tlast  = (i == frm_len - 1);
      axis.tuser  = (i == frm_len - 1) ? frm_tuser : 1'($urandom);
      start = st; stop = sp;
      @(posedge clk); #1;
      axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tuser = 1'b0; axis.tdata = '0;
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse(input bit st, input bit sp);
      start = st; stop = sp;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < frm_len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle_cycles(1);
         drive_beat(i, 1'b0, 1'b0);
      end
   endtask

   task automatic set_config(input logic [47:0] mac, input int len);
      port_config = {3'd2, 11'(len), 32'h0a00_0002, 32'h0a00_0001, 48'h02_00_00_00_00_99, mac};
   endtask

   task automatic begin_test(input logic [47:0] mac, input int len);
      set_config(mac, len);
      pulse(1'b1, 1'b0);
      model_reset(mac, len);
      check_val("start_ready_low", 128'(check_ready), 128'(0));
   endtask

   task automatic end_test(input string tag);
      int n = 0;
      pulse(1'b0, 1'b1);
      while (!check_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_val({tag, "_ready"}, 128'(check_ready), 128'(1));
      check_val({tag, "_state"}, 128'(dbg_state), 128'(ST_DONE));
      exp_q.push_back({exp_err, exp_good, exp_bytes});
      check_val({tag, "_results"}, check_results, exp_q.pop_front());
   endtask

   task automatic send_good(input bit gaps);
      build_frame(m_mac, 16'h0800, m_len, tx_seq, 1'b0);
      tx_seq++;
      send_frame(gaps);
      model_frame();
   endtask

   task automatic send_random_frame();
      logic [47:0] dst = m_mac;
      logic [15:0] et = 16'h0800;
      int          len = m_len;
      logic        tu = 1'b0;
      logic [31:0] seq = tx_seq;
      case ($urandom_range(0, 11))
         0: dst = m_mac ^ (48'd1 << $urandom_range(0, 47));
         1: et = 16'h86DD;
         2: len = $urandom_range(1, 13);
         3: len = m_len + $urandom_range(1, 10);
         4: tu = 1'b1;
         5: seq = tx_seq + 32'd2;
         6: len = $urandom_range(14, 45);
         default: ;
      endcase
      tx_seq = seq + 32'd1;
      build_frame(dst, et, len, seq, tu);
      send_frame(1'b1);
      model_frame();
   endtask

   // ---------------- stimulus ----------------
   logic [127:0] held;

   initial begin
      axis.tdata = '0; axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tuser = 1'b0;
      idle_cycles(3);
      rst_n = 1'b1;
      idle_cycles(1);
      check_val("reset_ready", 128'(check_ready), 128'(1));
      check_val("reset_results", check_results, 128'(0));
      check_val("reset_state", 128'(dbg_state), 128'(ST_IDLE));

      // Ten good 64-byte frames.
      begin_test(48'h02_00_00_00_00_01, 64);
      for (int f = 0; f < 10; f++) send_good(1'b1);
      end_test("good10");
      check_val("good10_frames", 128'(check_results[95:64]), 128'(10));
      check_val("good10_bytes", 128'(check_results[63:0]), 128'(640));

      // Errored: tuser on tlast, then a 65-byte frame.
      begin_test(48'h02_00_00_00_00_01, 64);
      build_frame(m_mac, 16'h0800, 64, tx_seq, 1'b1); tx_seq++;
      send_frame(1'b0); model_frame();
      build_frame(m_mac, 16'h0800, 65, tx_seq, 1'b0); tx_seq++;
      send_frame(1'b1); model_frame();
      end_test("errored");
      check_val("errored_err", 128'(check_results[127:96]), 128'(2));

      // Ignored: wrong MAC, IPv6 EtherType, 10-byte runt.
      begin_test(48'h02_00_00_00_00_01, 64);
      build_frame(48'h02_00_00_00_00_02, 16'h0800, 64, tx_seq, 1'b0); send_frame(1'b0); model_frame();
      build_frame(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 64, tx_seq, 1'b0); send_frame(1'b1); model_frame();
      build_frame(m_mac, 16'h86DD, 64, tx_seq, 1'b0); send_frame(1'b0); model_frame();
      build_frame(m_mac, 16'h0800, 10, tx_seq, 1'b0); send_frame(1'b0); model_frame();
      end_test("ignored");
      check_val("ignored_zero", check_results, 128'(0));

      // Stop at byte 30 of a good frame: drain until tlast.
      begin_test(48'h02_00_00_00_00_01, 64);
      build_frame(m_mac, 16'h0800, 64, tx_seq, 1'b0); tx_seq++;
      for (int i = 0; i < 30; i++) drive_beat(i, 1'b0, 1'b0);
      drive_beat(30, 1'b0, 1'b1);
      check_val("drain_state", 128'(dbg_state), 128'(ST_DRAIN));
      for (int i = 31; i < 64; i++) begin
         check_val("drain_ready_low", 128'(check_ready), 128'(0));
         drive_beat(i, 1'b0, 1'b0);
      end
      check_val("drain_pre_ready", 128'(check_ready), 128'(0));
      check_val("drain_pre_good", 128'(check_results[95:64]), 128'(0));
      idle_cycles(1);
      model_frame();
      check_val("drain_ready", 128'(check_ready), 128'(1));
      check_val("drain_good", 128'(check_results[95:64]), 128'(1));
      check_val("drain_results", check_results, {exp_err, exp_good, exp_bytes});

      // Stop while DONE is ignored; traffic while DONE is not counted.
      held = check_results;
      pulse(1'b0, 1'b1);
      check_val("done_stop_state", 128'(dbg_state), 128'(ST_DONE));
      build_frame(m_mac, 16'h0800, 64, tx_seq, 1'b0); tx_seq++;
      send_frame(1'b0);
      idle_cycles(2);
      check_val("done_frozen", check_results, held);

      // Start at byte 20 of a frame: that frame is dropped.
      set_config(48'h02_00_00_00_00_01, 64);
      build_frame(48'h02_00_00_00_00_01, 16'h0800, 64, tx_seq, 1'b0); tx_seq++;
      for (int i = 0; i < 20; i++) drive_beat(i, 1'b0, 1'b0);
      drive_beat(20, 1'b1, 1'b0);
      model_reset(48'h02_00_00_00_00_01, 64);
      check_val("midstart_ready_low", 128'(check_ready), 128'(0));
      for (int i = 21; i < 64; i++) drive_beat(i, 1'b0, 1'b0);
      send_good(1'b0);
      end_test("midstart");
      check_val("midstart_good", 128'(check_results[95:64]), 128'(1));

      // Sequence numbers 5, 6, 8, 9.
      begin_test(48'h02_00_00_00_00_01, 64);
      for (int k = 0; k < 4; k++) begin
         build_frame(m_mac, 16'h0800, 64, (k < 2) ? 32'(5 + k) : 32'(6 + k), 1'b0);
         send_frame(1'b1);
         model_frame();
      end
      end_test("seq");

      // Randomized windows, first one restarted halfway through.
      for (int w = 0; w < 3; w++) begin
         begin_test(48'({$urandom(), $urandom()}), $urandom_range(46, 100));
         for (int f = 0; f < 14; f++) begin
            if (w == 0 && f == 7) begin
               pulse(1'b1, 1'b0);
               model_reset(m_mac, m_len);
            end
            send_random_frame();
         end
         end_test("random");
      end

      // Reset in the middle of a test.
      begin_test(48'h02_00_00_00_00_01, 64);
      send_good(1'b0);
      send_good(1'b1);
      build_frame(m_mac, 16'h0800, 64, tx_seq, 1'b0);
      for (int i = 0; i < 10; i++) drive_beat(i, 1'b0, 1'b0);
      rst_n = 1'b0;
      idle_cycles(1);
      check_val("midreset_ready", 128'(check_ready), 128'(1));
      check_val("midreset_results", check_results, 128'(0));
      check_val("midreset_state", 128'(dbg_state), 128'(ST_IDLE));
      rst_n = 1'b1;
      idle_cycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/speed_test_frame_checker.md
Name: speed_test_frame_checker

Overview:
- Per-port receive-side checker that consumes the byte stream from one test port's MAC RX.
- Driven by the speed test controller via start, stop and port_config. Returns check_ready and a 128-bit result word to the controller.
- Counts matching good frames, good bytes and errored frames during a test window. Results are frozen once the test ends.

Parameters:
- ETHERTYPE, 16'h0800, EtherType a frame must carry to be considered test traffic.
- MIN_HDR_LEN, 14, bytes needed before a frame can be classified; shorter frames are ignored.

Ports:
- clk  in  1  clock (125 MHz domain)
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  8  RX byte
- s_axis_tvalid  in  1  byte valid
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  MAC error flag, sampled on the tlast beat
- start  in  1  one-cycle pulse: begin test
- stop  in  1  one-cycle pulse: end test
- port_config  in  174  test config:
  - [47:0] local MAC, matched as the destination
  - [95:48] remote MAC
  - [127:96] src IP
  - [159:128] dst IP
  - [170:160] frame length in bytes, excluding FCS
  - [173:171] rate select (generator only)
- check_ready  out  1  high when idle or done; results valid
- check_results  out  128  [63:0] good bytes, [95:64] good frames, [127:96] error frames

Behaviour:
- No tready. The stream is never stalled; every tvalid beat is consumed.
- Reset: state IDLE, check_ready=1, check_results=0, in-frame flags and byte index cleared.
- States and transitions:
  - IDLE or DONE, on start: clear all counters, latch port_config[47:0] and [170:160], go to RUNNING. check_ready=0 from the next cycle.
  - RUNNING, on stop: go to DRAIN if a frame is in progress, else DONE.
  - DRAIN: stay until the current frame's tlast beat has been accounted, then go to DONE.
  - DONE: check_ready=1 the cycle after the final counter update. Results are held until the next start.
  - start in RUNNING or DRAIN restarts: counters cleared, config relatched, state RUNNING.
  - start and stop in the same cycle: start wins.
  - stop in IDLE or DONE is ignored.
- Frame sync:
  - On entering RUNNING while a frame is mid-flight (a beat seen without tlast before start), that frame is ignored.
  - Classification begins at the first byte after a tlast.
- Byte index: 11-bit, increments per tvalid beat, saturates at 2047, resets after tlast.
- Frame matches when bytes 0–5 equal the latched MAC (byte 0 = bits [47:40]) and bytes 12–13 equal ETHERTYPE.
  - Non-matching frames, and frames with fewer than MIN_HDR_LEN bytes, are ignored and not counted.
- On the tlast beat of a matching frame:
  - Good: tuser=0 and length equals latched length. good frames +1, good bytes += length.
  - Otherwise: error frames +1.
  - Counters update one cycle after the tlast beat.
- Frame counters saturate at 32'hFFFFFFFF. The byte counter is 64-bit and wraps modulo 2^64.
- Counting happens only in RUNNING and DRAIN. Frames starting in DRAIN are not possible because DRAIN exits at tlast.
- Reset mid-test: immediate return to the reset state; partial results are lost.

Optional Feature:
- Macro: SPEED_TEST_CHECKER_SEQ_EN.
- When defined:
  - Bytes 42–45 (big-endian) of a matching frame hold a 32-bit sequence number.
  - The first matching frame after start sets expected = seq+1.
  - A later frame whose seq differs from expected is counted as an error frame even if otherwise good; expected resyncs to seq+1.
  - Frames shorter than 46 bytes count as errors.
- When undefined: bytes 42–45 are not inspected and there is no sequence state.

Decomposition:
- Shared package speed_test_pkg holds:
  - port_config field offsets and widths
  - check_results field offsets
  - checker state enum (IDLE, RUNNING, DRAIN, DONE)
  - ETHERTYPE_IPV4 constant
- One sub-module, speed_test_frame_parser: tracks byte index, header match and sequence, and outputs a one-cycle verdict (valid, match, good, length) per frame.
- The top level holds the FSM and counters.

Test Plan:
- Reset, no traffic: check_ready=1 and check_results=0.
- Config MAC 02:00:00:00:00:01, length 64; start; 10 good 64-byte frames; stop: good frames=10, good bytes=640, errors=0; check_ready=1.
- Errored frames: one frame with tuser=1 on tlast plus one 65-byte frame, then stop: errors=2, good frames=0.
- Ignored frames: frames to a different MAC, a frame with EtherType 0x86DD, and a 10-byte runt, then stop: all counters 0.
- Stop at byte 30 of a good frame: check_ready stays 0 until tlast; then good frames=1 and ready=1 one cycle after the update.
- Start pulse at byte 20 of a frame: that frame is not counted; the next good frame is counted (good frames=1).
- With SPEED_TEST_CHECKER_SEQ_EN, send seq 5, 6, 8, 9: good frames=3, errors=1.
